// File: rtl/rv32_mod_exec_sequencer.sv
// Multi-cycle control sequencer for the rv32imc core: fetch, execute, optional
// memory access and a one-cycle trap, wrapped around the combinational decoder.
module rv32_mod_exec_sequencer #(
  parameter int TIMEOUT   = 255,
  parameter int TIMEOUT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req,
  input  logic        ifu_ack,
  input  logic        ifu_err,
  output logic        ir_load,
  input  logic        dec_illegal,
  input  logic        dec_rf_write0_enable,
  input  logic        dec_mem_access,
  input  logic        dec_ram_wr,
  input  logic        dec_br_is_cond,
  input  logic        dec_br_jmp,
  input  logic        br_taken,
  output logic        lsu_req,
  output logic        lsu_wr,
  input  logic        lsu_ack,
  input  logic        lsu_err,
  output logic        rf_write0_enable,
  output logic        pc_write,
  output logic [1:0]  pc_sel,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_RESET,
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_TRAP
  } state_t;

  state_t                state, state_nxt;
  logic [TIMEOUT_W-1:0]  wait_cnt;
  logic [1:0]            cause_q, cause_nxt;
  logic [31:0]           instret_q;
  logic                  retire;
  logic                  waiting;
  logic                  timed_out;

  assign timed_out = (TIMEOUT != 0) && (wait_cnt == TIMEOUT_W'(TIMEOUT - 1));

  // rst gates every output in the same cycle so a pending handshake is abandoned at once
  always_comb begin
    state_nxt        = state;
    cause_nxt        = cause_q;
    ifu_req          = 1'b0;
    ir_load          = 1'b0;
    lsu_req          = 1'b0;
    lsu_wr           = 1'b0;
    rf_write0_enable = 1'b0;
    pc_write         = 1'b0;
    pc_sel           = 2'd0;
    trap             = 1'b0;
    trap_cause       = 2'd0;
    retire           = 1'b0;
    waiting          = 1'b0;
    case (state)
      S_RESET: state_nxt = S_FETCH;
      S_FETCH: begin
        ifu_req = 1'b1;
        if (ifu_err) begin
          state_nxt = S_TRAP;
          cause_nxt = 2'd1;
        end else if (ifu_ack) begin
          ir_load   = 1'b1;
          state_nxt = S_EXEC;
        end else begin
          waiting = 1'b1;
          if (timed_out) begin
            state_nxt = S_TRAP;
            cause_nxt = 2'd1;
          end
        end
      end
      S_EXEC: begin
        if (dec_illegal) begin
          state_nxt = S_TRAP;
          cause_nxt = 2'd2;
        end else if (dec_mem_access) begin
          state_nxt = S_MEM;
        end else begin
          rf_write0_enable = dec_rf_write0_enable;
          pc_write         = 1'b1;
          pc_sel           = (dec_br_jmp | (dec_br_is_cond & br_taken)) ? 2'd1 : 2'd0;
          retire           = 1'b1;
          state_nxt        = S_FETCH;
        end
      end
      S_MEM: begin
        lsu_req = 1'b1;
        lsu_wr  = dec_ram_wr;
        if (lsu_err) begin
          state_nxt = S_TRAP;
          cause_nxt = 2'd3;
        end else if (lsu_ack) begin
          rf_write0_enable = dec_rf_write0_enable & ~dec_ram_wr;
          pc_write         = 1'b1;
          retire           = 1'b1;
          state_nxt        = S_FETCH;
        end else begin
          waiting = 1'b1;
          if (timed_out) begin
            state_nxt = S_TRAP;
            cause_nxt = 2'd3;
          end
        end
      end
      S_TRAP: begin
        trap       = 1'b1;
        trap_cause = cause_q;
        pc_write   = 1'b1;
        pc_sel     = 2'd2;
        state_nxt  = S_FETCH;
      end
      default: state_nxt = S_RESET;
    endcase
    if (rst) begin
      ifu_req          = 1'b0;
      ir_load          = 1'b0;
      lsu_req          = 1'b0;
      lsu_wr           = 1'b0;
      rf_write0_enable = 1'b0;
      pc_write         = 1'b0;
      pc_sel           = 2'd0;
      trap             = 1'b0;
      trap_cause       = 2'd0;
      retire           = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_RESET;
      cause_q   <= 2'd0;
      wait_cnt  <= '0;
      instret_q <= 32'd0;
    end else begin
      state   <= state_nxt;
      cause_q <= cause_nxt;
      if (retire)
        instret_q <= instret_q + 32'd1;
      // the wait counter restarts on every state change and saturates otherwise
      if (state_nxt != state)
        wait_cnt <= '0;
      else if (waiting && (wait_cnt != {TIMEOUT_W{1'b1}}))
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign instret = rst ? 32'd0 : instret_q;

endmodule

// File: tb/tb_rv32_mod_exec_sequencer.sv
// Scoreboard bench for rv32_mod_exec_sequencer: each instruction pushes its expected
// completion (retire or trap) and a monitor pops it whenever pc_write is seen.
module tb_rv32_mod_exec_sequencer;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifu_req, ir_load, lsu_req, lsu_wr;
  logic        ifu_ack = 1'b0, ifu_err = 1'b0, lsu_ack = 1'b0, lsu_err = 1'b0;
  logic        dec_illegal = 1'b0, dec_rf_write0_enable = 1'b0, dec_mem_access = 1'b0;
  logic        dec_ram_wr = 1'b0, dec_br_is_cond = 1'b0, dec_br_jmp = 1'b0, br_taken = 1'b0;
  logic        rf_write0_enable, pc_write, trap;
  logic [1:0]  pc_sel, trap_cause;
  logic [31:0] instret;

  typedef struct {
    logic        rf;
    logic [1:0]  sel;
    logic        trp;
    logic [1:0]  cause;
    logic [31:0] instret;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] model_instret = 32'd0;
  int          tests = 0;
  int          fails = 0;

  rv32_mod_exec_sequencer #(.TIMEOUT(TO), .TIMEOUT_W(8)) dut (
    .clk(clk), .rst(rst),
    .ifu_req(ifu_req), .ifu_ack(ifu_ack), .ifu_err(ifu_err), .ir_load(ir_load),
    .dec_illegal(dec_illegal), .dec_rf_write0_enable(dec_rf_write0_enable),
    .dec_mem_access(dec_mem_access), .dec_ram_wr(dec_ram_wr),
    .dec_br_is_cond(dec_br_is_cond), .dec_br_jmp(dec_br_jmp), .br_taken(br_taken),
    .lsu_req(lsu_req), .lsu_wr(lsu_wr), .lsu_ack(lsu_ack), .lsu_err(lsu_err),
    .rf_write0_enable(rf_write0_enable), .pc_write(pc_write), .pc_sel(pc_sel),
    .trap(trap), .trap_cause(trap_cause), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Completion monitor: sampled on the falling edge, well away from the active edge
  always @(negedge clk) begin
    if (!rst && rf_write0_enable && trap)
      checkOutput("rf_trap_exclusive", 32'd1, 32'd0);
    if (!rst && pc_write) begin
      if (sbq.size() == 0) begin
        checkOutput("unexpected_pc_write", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        checkOutput("done:rf_write", 32'(rf_write0_enable), 32'(e.rf));
        checkOutput("done:pc_sel", 32'(pc_sel), 32'(e.sel));
        checkOutput("done:trap", 32'(trap), 32'(e.trp));
        checkOutput("done:trap_cause", 32'(trap_cause), 32'(e.cause));
        checkOutput("done:instret", instret, e.instret);
      end
    end
  end

  task automatic clearDecode();
    dec_illegal = 0; dec_rf_write0_enable = 0; dec_mem_access = 0;
    dec_ram_wr = 0; dec_br_is_cond = 0; dec_br_jmp = 0; br_taken = 0;
  endtask

  // One instruction: fw/mw are wait cycles before ack (>= TO means never acked)
  task automatic applyStimulus(input string name, input int fw, input bit ferr,
                               input bit ill, input bit rfw, input bit mem, input bit wr,
                               input bit cond, input bit jmp, input bit taken,
                               input int mw, input bit lerr);
    exp_t e;
    bit   f_trap, m_trap;
    int   k;
    f_trap = ferr || (fw >= TO);
    m_trap = lerr || (mw >= TO);
    e.instret = model_instret;
    e.rf = 0; e.sel = 2'd0; e.trp = 0; e.cause = 2'd0;
    if (f_trap) begin
      e.trp = 1; e.cause = 2'd1; e.sel = 2'd2;
    end else if (ill) begin
      e.trp = 1; e.cause = 2'd2; e.sel = 2'd2;
    end else if (mem && m_trap) begin
      e.trp = 1; e.cause = 2'd3; e.sel = 2'd2;
    end else if (mem) begin
      e.rf = rfw & ~wr;
      model_instret = model_instret + 32'd1;
    end else begin
      e.rf = rfw;
      e.sel = (jmp | (cond & taken)) ? 2'd1 : 2'd0;
      model_instret = model_instret + 32'd1;
    end
    sbq.push_back(e);

    for (int i = 0; i < 10 && !ifu_req; i++) begin @(posedge clk); #1; end
    k = 0;
    while (ifu_req && k < 20) begin
      if (k == fw) begin
        ifu_ack = 1; ifu_err = ferr;
        dec_illegal = ill; dec_rf_write0_enable = rfw; dec_mem_access = mem;
        dec_ram_wr = wr; dec_br_is_cond = cond; dec_br_jmp = jmp; br_taken = taken;
        #1;
        checkOutput({name, ":ir_load"}, 32'(ir_load), 32'(!ferr));
      end
      @(posedge clk); #1;
      ifu_ack = 0; ifu_err = 0;
      k++;
    end
    checkOutput({name, ":ifu_req_cycles"}, 32'(k), 32'((fw >= TO) ? TO : fw + 1));

    if (!f_trap && !ill && mem) begin
      for (int i = 0; i < 10 && !lsu_req; i++) begin @(posedge clk); #1; end
      k = 0;
      while (lsu_req && k < 20) begin
        if (k == 0) checkOutput({name, ":lsu_wr"}, 32'(lsu_wr), 32'(wr));
        if (k == mw) begin lsu_ack = 1; lsu_err = lerr; end
        @(posedge clk); #1;
        lsu_ack = 0; lsu_err = 0;
        k++;
      end
      checkOutput({name, ":lsu_req_cycles"}, 32'(k), 32'((mw >= TO) ? TO : mw + 1));
    end

    for (int i = 0; i < 10 && sbq.size() != 0; i++) begin @(posedge clk); #1; end
    checkOutput({name, ":completed"}, 32'(sbq.size() == 0), 32'd1);
    clearDecode();
  endtask

  task automatic doReset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst:ifu_req", 32'(ifu_req), 32'd0);
    checkOutput("rst:pc_write", 32'(pc_write), 32'd0);
    checkOutput("rst:instret", instret, 32'd0);
    rst = 0;
    model_instret = 32'd0;
    #1;
    checkOutput("rst:first_cycle_ifu_req", 32'(ifu_req), 32'd0);
    @(posedge clk); #1;
    checkOutput("rst:fetch_starts", 32'(ifu_req), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    @(posedge clk); #1;
    doReset();
    //             name     fw ferr ill rfw mem wr cond jmp tkn mw lerr
    applyStimulus("addi",   0, 0,   0,  1,  0,  0, 0,   0,  0,  0, 0);
    applyStimulus("beq_t",  1, 0,   0,  0,  0,  0, 1,   0,  1,  0, 0);
    applyStimulus("beq_nt", 0, 0,   0,  0,  0,  0, 1,   0,  0,  0, 0);
    applyStimulus("jal",    2, 0,   0,  1,  0,  0, 0,   1,  0,  0, 0);
    applyStimulus("load",   0, 0,   0,  1,  1,  0, 0,   0,  0,  3, 0);
    applyStimulus("store",  0, 0,   0,  1,  1,  1, 0,   0,  0,  0, 0);
    applyStimulus("illeg",  0, 0,   1,  1,  0,  0, 0,   0,  0,  0, 0);
    applyStimulus("if_to",  9, 0,   0,  1,  0,  0, 0,   0,  0,  0, 0);
    applyStimulus("if_err", 1, 1,   0,  1,  0,  0, 0,   0,  0,  0, 0);
    applyStimulus("ls_err", 0, 0,   0,  1,  1,  0, 0,   0,  0,  1, 1);
    applyStimulus("ls_to",  0, 0,   0,  1,  1,  1, 0,   0,  0,  9, 0);

    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    model_instret = 32'hFFFF_FFFF;
    applyStimulus("wrap",   0, 0,   0,  1,  0,  0, 0,   0,  0,  0, 0);
    checkOutput("wrap:instret_zero", instret, 32'd0);
    applyStimulus("post",   0, 0,   0,  1,  0,  0, 0,   0,  0,  0, 0);

    // Reset in the middle of a load handshake, with the ack arriving in the same cycle
    for (int i = 0; i < 10 && !ifu_req; i++) begin @(posedge clk); #1; end
    ifu_ack = 1; dec_mem_access = 1; dec_rf_write0_enable = 1;
    @(posedge clk); #1;
    ifu_ack = 0;
    @(posedge clk); #1;
    checkOutput("rstmem:lsu_req_before", 32'(lsu_req), 32'd1);
    rst = 1; lsu_ack = 1;
    #1;
    checkOutput("rstmem:lsu_req_dropped", 32'(lsu_req), 32'd0);
    checkOutput("rstmem:no_rf_write", 32'(rf_write0_enable), 32'd0);
    checkOutput("rstmem:instret", instret, 32'd0);
    @(posedge clk); #1;
    lsu_ack = 0;
    clearDecode();
    doReset();
    applyStimulus("restart", 0, 0,  0,  1,  0,  0, 0,   0,  0,  0, 0);
    checkOutput("restart:instret", instret, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rv32_mod_exec_sequencer.md
Name: rv32_mod_exec_sequencer

Overview:
- Multi-cycle control FSM for the rv32imc core. Sequences instruction fetch, execute, optional memory access and writeback around the combinational instruction decoder.
- Gates the register-file write and PC update, and selects the next-PC source.
- Converts bus faults, bus timeouts and illegal instructions into a one-cycle trap sequence.
- Maintains the retired-instruction counter (minstret source).

Parameters:
- TIMEOUT, 255, max wait cycles on the ifu/lsu handshake before a fault; 0 disables the timeout.
- TIMEOUT_W, 8, width of the wait counter; TIMEOUT must fit in it.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ifu_req  out  1  instruction fetch request
- ifu_ack  in  1  fetch done; instruction valid this cycle
- ifu_err  in  1  fetch bus fault
- ir_load  out  1  latch fetched instruction into IR
- dec_illegal  in  1  decoder: IR is illegal
- dec_rf_write0_enable  in  1  decoder: instruction writes rd
- dec_mem_access  in  1  decoder: load or store (wb_source == LSU or ram_wr)
- dec_ram_wr  in  1  decoder: store
- dec_br_is_cond  in  1  decoder: conditional branch
- dec_br_jmp  in  1  decoder: unconditional jump
- br_taken  in  1  comparator result for br_cond
- lsu_req  out  1  data memory request
- lsu_wr  out  1  request is a store
- lsu_ack  in  1  data access done; load data valid this cycle
- lsu_err  in  1  data bus fault
- rf_write0_enable  out  1  register-file write strobe
- pc_write  out  1  PC update strobe
- pc_sel  out  2  next-PC source: 0 = pc + inst length, 1 = branch/jump target, 2 = trap vector
- trap  out  1  trap taken this cycle
- trap_cause  out  2  cause: 0 = none, 1 = fetch fault, 2 = illegal instruction, 3 = load/store fault
- instret  out  32  retired-instruction count

Behaviour:
- Reset is synchronous and active-high. While rst is high, and on the first cycle after it, all outputs are 0 and instret = 0. The FSM enters RESET, then moves to FETCH.
- State is registered. All control outputs decode combinationally from state and current inputs.
- States: RESET, FETCH, EXEC, MEM, TRAP.
- RESET -> FETCH unconditionally.
- FETCH: ifu_req = 1.
  - ifu_err -> TRAP, cause 1.
  - Otherwise ifu_ack -> ir_load = 1 and go to EXEC.
  - Otherwise stay. If the wait counter reaches TIMEOUT -> TRAP, cause 1.
  - err wins over a simultaneous ack.
- EXEC (one cycle):
  - dec_illegal -> TRAP, cause 2. No rf or pc write.
  - Otherwise dec_mem_access -> MEM.
  - Otherwise:
    - rf_write0_enable = dec_rf_write0_enable
    - pc_write = 1
    - pc_sel = 1 if dec_br_jmp | (dec_br_is_cond & br_taken), else 0
    - instret increments; go to FETCH.
- MEM: lsu_req = 1, lsu_wr = dec_ram_wr; both held stable until the exit cycle.
  - lsu_err, or timeout -> TRAP, cause 3.
  - Otherwise lsu_ack -> rf_write0_enable = dec_rf_write0_enable & ~dec_ram_wr, pc_write = 1, pc_sel = 0, instret increments, go to FETCH.
- TRAP (one cycle): trap = 1, trap_cause = latched cause, pc_write = 1, pc_sel = 2, rf_write0_enable = 0, no instret increment. Then go to FETCH.
- trap_cause is 0 outside TRAP.
- Wait counter:
  - Cleared on every state entry.
  - Increments each cycle spent in FETCH or MEM without ack/err.
  - Saturates; timeout fires when counter == TIMEOUT - 1 with no ack in that cycle, so the maximum wait is TIMEOUT cycles.
  - TIMEOUT = 0 disables the timeout.
- ifu_req/lsu_req drop the cycle after ack because the state changes. Back-to-back fetches have a minimum 1-cycle gap (the EXEC state).
- Latency:
  - non-memory instruction: 2 cycles with zero-wait fetch
  - load/store: 3 cycles
- instret wraps from 0xFFFFFFFF to 0.
- rst mid-handshake: requests drop in the same cycle, pending ack is ignored, and FETCH restarts from RESET.
- At most one of rf_write0_enable / trap is active in any cycle.

Test Plan:
- Reset, then zero-wait fetch of an ADDI (rf_write=1, no mem): ifu_req high on cycle 2; ir_load on ack; next cycle rf_write0_enable=1, pc_write=1, pc_sel=0; instret=1.
- Taken BEQ (br_is_cond=1, br_taken=1, rf_write=0): EXEC gives pc_sel=1, rf_write0_enable=0. Same with br_taken=0 -> pc_sel=0.
- Load with lsu_ack after 3 wait cycles: lsu_req high 4 cycles with lsu_wr=0; on ack rf_write0_enable=1, pc_write=1; instret+1. Store variant: lsu_wr=1, rf_write0_enable=0.
- dec_illegal=1 in EXEC -> next cycle trap=1, trap_cause=2, pc_sel=2, pc_write=1; instret unchanged; then FETCH.
- TIMEOUT=4, ifu_ack never asserted -> ifu_req high exactly 4 cycles, then trap with cause 1. Also lsu_err and lsu_ack asserted together -> trap with cause 3, no rf write.
- instret preset near wrap (run 2^32 - 1 retires via backdoor force) -> wraps to 0. rst asserted during MEM -> lsu_req drops that cycle; sequence restarts with instret=0.
